// File: rtl/qed_pkg.sv
// Shared encodings for the SQED instruction tracker: opcodes, funct fields,
// violation codes, FSM states and the register-partition rule.
package qed_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_NOP    = 7'b1111111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_SR      = 3'b101;

  typedef enum logic [2:0] {
    VC_NONE      = 3'd0,
    VC_ILLEGAL   = 3'd1,
    VC_PARTITION = 3'd2,
    VC_OVERFLOW  = 3'd3,
    VC_UNDERFLOW = 3'd4,
    VC_ORDER     = 3'd5,
    VC_MISMATCH  = 3'd6
  } viol_code_e;

  typedef enum logic [1:0] {S_ORIG, S_DUP, S_DONE, S_ERR} state_e;

  typedef enum logic [2:0] {FMT_NONE, FMT_R, FMT_I, FMT_LOAD, FMT_STORE, FMT_NOP} fmt_e;

  typedef struct packed {
    logic rd;
    logic rs1;
    logic rs2;
  } field_mask_t;

  // x0 is shared; any other register must sit in its stream's half of the file.
  function automatic logic field_ok(logic [4:0] f, logic dup, int unsigned num_regs);
    if (32'(f) >= num_regs) return 1'b0;
    if (f == 5'd0) return 1'b1;
    return dup ? (32'(f) >= num_regs / 2) : (32'(f) < num_regs / 2);
  endfunction

endpackage

// File: rtl/qed_inst_tracker_if.sv
// Issue-port bundle between the formal harness and qed_inst_tracker.
interface qed_inst_tracker_if #(
  parameter int unsigned DEPTH = 16
) ();
  logic                           inst_valid;
  logic [31:0]                    instruction;
  logic                           exec_dup;
  logic                           legal;
  logic                           violation;
  logic [2:0]                     viol_code;
  logic                           qed_ready;
  logic [$clog2(DEPTH+1)-1:0]     occupancy;

  modport master (
    output inst_valid, instruction, exec_dup,
    input  legal, violation, viol_code, qed_ready, occupancy
  );

  modport slave (
    input  inst_valid, instruction, exec_dup,
    output legal, violation, viol_code, qed_ready, occupancy
  );
endinterface

// File: rtl/qed_inst_decode.sv
// Combinational RV32 subset decoder: legality, format, used register fields and
// stream partition check. Build with QED_MULDIV_EN to admit MUL/MULH/MULHSU/MULHU.
module qed_inst_decode
  import qed_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic [31:0] instruction_i,
  input  logic        exec_dup_i,
  output logic        legal_o,
  output fmt_e        fmt_o,
  output field_mask_t mask_o,
  output logic        partition_ok_o
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic       muldiv_ok;

  assign opcode = instruction_i[6:0];
  assign rd     = instruction_i[11:7];
  assign funct3 = instruction_i[14:12];
  assign rs1    = instruction_i[19:15];
  assign rs2    = instruction_i[24:20];
  assign funct7 = instruction_i[31:25];

`ifdef QED_MULDIV_EN
  assign muldiv_ok = (funct7 == F7_MULDIV) && !funct3[2];
`else
  assign muldiv_ok = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    legal_o = 1'b0;
    fmt_o   = FMT_NONE;
    case (opcode)
      OPC_OP: begin
        legal_o = (funct7 == F7_BASE) || muldiv_ok ||
                  ((funct7 == F7_ALT) && (funct3 == F3_ADD_SUB || funct3 == F3_SR));
        fmt_o   = FMT_R;
      end
      OPC_OP_IMM: begin
        case (funct3)
          F3_SLL:  legal_o = (funct7 == F7_BASE);
          F3_SR:   legal_o = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal_o = 1'b1;
        endcase
        fmt_o = FMT_I;
      end
      OPC_LOAD: begin
        legal_o = (funct3 == F3_WORD) && (rs1 == 5'd0);
        fmt_o   = FMT_LOAD;
      end
      OPC_STORE: begin
        legal_o = (funct3 == F3_WORD) && (rs1 == 5'd0);
        fmt_o   = FMT_STORE;
      end
      OPC_NOP: begin
        legal_o = 1'b1;
        fmt_o   = FMT_NOP;
      end
      default: ;
    endcase
    if (!legal_o) fmt_o = FMT_NONE;
  end

  always_comb begin
    mask_o = '0;
    case (fmt_o)
      FMT_R:     mask_o = '{rd: 1'b1, rs1: 1'b1, rs2: 1'b1};
      FMT_I:     mask_o = '{rd: 1'b1, rs1: 1'b1, rs2: 1'b0};
      FMT_LOAD:  mask_o = '{rd: 1'b1, rs1: 1'b0, rs2: 1'b0};
      FMT_STORE: mask_o = '{rd: 1'b0, rs1: 1'b0, rs2: 1'b1};
      default:   mask_o = '0;
    endcase
  end

  assign partition_ok_o = (!mask_o.rd  || field_ok(rd,  exec_dup_i, NUM_REGS)) &&
                          (!mask_o.rs1 || field_ok(rs1, exec_dup_i, NUM_REGS)) &&
                          (!mask_o.rs2 || field_ok(rs2, exec_dup_i, NUM_REGS));

endmodule

// File: rtl/qed_inst_tracker.sv
// SQED original/duplicate tracker: buffers originals, checks each duplicate replays
// its original in order. Optional MUL* support via QED_MULDIV_EN (see qed_inst_decode).
module qed_inst_tracker
  import qed_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DEPTH    = 16
) (
  input logic               clk,
  input logic               rst,
  qed_inst_tracker_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [4:0]  HALF  = 5'(NUM_REGS / 2);

  logic        legal, part_ok;
  fmt_e        fmt;
  field_mask_t mask;

  qed_inst_decode #(.NUM_REGS(NUM_REGS)) u_decode (
    .instruction_i  (bus.instruction),
    .exec_dup_i     (bus.exec_dup),
    .legal_o        (legal),
    .fmt_o          (fmt),
    .mask_o         (mask),
    .partition_ok_o (part_ok)
  );

  logic [31:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  viol_code_e       code_q, code_d, fault;
  logic             violation_q, violation_d, qed_ready_q, qed_ready_d;
  logic             push, pop;
  logic [31:0]      dup_image;

  // The FIFO holds the duplicate each original must be replayed as, so a pop is a plain compare.
  always_comb begin
    dup_image = bus.instruction;
    if (mask.rd  && bus.instruction[11:7]  != 5'd0) dup_image[11:7]  = bus.instruction[11:7]  + HALF;
    if (mask.rs1 && bus.instruction[19:15] != 5'd0) dup_image[19:15] = bus.instruction[19:15] + HALF;
    if (mask.rs2 && bus.instruction[24:20] != 5'd0) dup_image[24:20] = bus.instruction[24:20] + HALF;
  end

  always_comb begin
    state_d     = state_q;
    violation_d = violation_q;
    code_d      = code_q;
    qed_ready_d = qed_ready_q;
    push        = 1'b0;
    pop         = 1'b0;
    fault       = VC_NONE;
    if (bus.inst_valid && state_q != S_ERR) begin
      if (!legal)        fault = VC_ILLEGAL;
      else if (!part_ok) fault = VC_PARTITION;
      else if (fmt != FMT_NOP) begin
        if (!bus.exec_dup) begin
          if (state_q == S_DUP)               fault = VC_ORDER;
          else if (count_q == CNT_W'(DEPTH))  fault = VC_OVERFLOW;
          else begin
            push        = 1'b1;
            qed_ready_d = 1'b0;
            state_d     = S_ORIG;
          end
        end else if (count_q == '0) begin
          fault = VC_UNDERFLOW;
        end else begin
          pop = 1'b1;
          if (fifo_mem[rd_ptr_q] != bus.instruction) fault = VC_MISMATCH;
          else if (count_q == CNT_W'(1)) begin
            state_d     = S_DONE;
            qed_ready_d = 1'b1;
          end else begin
            state_d = S_DUP;
          end
        end
      end
      if (fault != VC_NONE) begin
        violation_d = 1'b1;
        code_d      = fault;
        state_d     = S_ERR;
      end
    end
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ORIG;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      violation_q <= 1'b0;
      code_q      <= VC_NONE;
      qed_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      violation_q <= violation_d;
      code_q      <= code_d;
      qed_ready_q <= qed_ready_d;
    end
  end

  // NOTE: storage is not reset; count_q gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= dup_image;
  end

  assign bus.legal     = legal;
  assign bus.violation = violation_q;
  assign bus.viol_code = code_q;
  assign bus.qed_ready = qed_ready_q;
  assign bus.occupancy = count_q;

endmodule
